// File: rtl/cpu_pkg.sv
// Shared definitions for the MEM/WB stage: FSM encoding, the captured
// memory command, widths and the default acknowledge timeout.
package cpu_pkg;

  localparam int ACK_TIMEOUT_DEFAULT = 16;
  localparam int XLEN                = 32;
  localparam int REG_AW              = 5;
  localparam int CNT_W               = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  // Request captured on entry to WAIT and held stable on the memory port.
  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } mem_cmd_t;

  // An instruction needs the data memory if it reads or writes it.
  function automatic logic is_mem_op(input logic rd, input logic wr);
    return rd | wr;
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A stalled edge inserts a bubble by clearing
// the write-back controls while keeping the payload fields unchanged.
module mem_wb_reg
  import cpu_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              kill_wr_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic [REG_AW-1:0] Rd_i,
  input  logic [XLEN-1:0]   ALUResult_i,
  input  logic [XLEN-1:0]   ReadData_i,
  output logic              RegWrite_o,
  output logic              MemtoReg_o,
  output logic [REG_AW-1:0] Rd_o,
  output logic [XLEN-1:0]   ALUResult_o,
  output logic [XLEN-1:0]   ReadData_o
);

  logic              reg_write_q;
  logic              mem_to_reg_q;
  logic [REG_AW-1:0] rd_q;
  logic [XLEN-1:0]   alu_result_q;
  logic [XLEN-1:0]   read_data_q;

  // Load the instruction when not stalled, otherwise load a bubble.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      rd_q         <= '0;
      alu_result_q <= '0;
      read_data_q  <= '0;
    end else if (stall_i) begin
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else begin
      // An aborted access must never write the register file.
      reg_write_q  <= RegWrite_i & ~kill_wr_i;
      mem_to_reg_q <= MemtoReg_i;
      rd_q         <= Rd_i;
      alu_result_q <= ALUResult_i;
      read_data_q  <= ReadData_i;
    end
  end

  assign RegWrite_o  = reg_write_q;
  assign MemtoReg_o  = mem_to_reg_q;
  assign Rd_o        = rd_q;
  assign ALUResult_o = alu_result_q;
  assign ReadData_o  = read_data_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage with a handshaked data-memory port, acknowledge timeout and
// pipeline stall, feeding the MEM/WB register.
module mem_wb_stage
  import cpu_pkg::*;
#(
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [REG_AW-1:0] Rd_i,
  input  logic [XLEN-1:0]   ALUResult_i,
  input  logic [XLEN-1:0]   DATAWr_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  output logic              stall_o,
  output logic              RegWrite_o,
  output logic              MemtoReg_o,
  output logic [REG_AW-1:0] Rd_o,
  output logic [XLEN-1:0]   ALUResult_o,
  output logic [XLEN-1:0]   ReadData_o,
  output logic              mem_err_o
);

  // Last WAIT cycle index; an unacknowledged request aborts there.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mem_cmd_t         cmd_q, cmd_d;
  logic [XLEN-1:0]  rdata_q, rdata_d;
  logic             abort_q, abort_d;
  logic             err_q, err_d;

  logic             mem_op;
  logic             req;
  logic             stall;
  logic             wb_kill;
  logic [XLEN-1:0]  wb_rdata;

  assign mem_op = is_mem_op(MemRead_i, MemWrite_i);

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: ack wins over timeout in the final WAIT cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mem_op) state_d = ST_WAIT;
      ST_WAIT: if (mem_ack_i || (cnt_q == CNT_LAST)) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: request only in WAIT; stall while the access is pending.
  always_comb begin
    req   = (state_q == ST_WAIT);
    stall = (state_q == ST_WAIT) || ((state_q == ST_IDLE) && mem_op);
  end

  // Datapath next state: command capture, timeout counter, load data, error.
  always_comb begin
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    rdata_d = rdata_q;
    abort_d = abort_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_op) begin
          // A simultaneous read and write is issued as a write.
          cmd_d.we    = MemWrite_i;
          cmd_d.addr  = ALUResult_i;
          cmd_d.wdata = DATAWr_i;
          cnt_d       = '0;
          rdata_d     = '0;
          abort_d     = 1'b0;
        end
      end
      ST_WAIT: begin
        if (mem_ack_i) begin
          if (!cmd_q.we) rdata_d = mem_rdata_i;
        end else if (cnt_q == CNT_LAST) begin
          abort_d = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; the error flag only ever sets until reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q   <= '0;
      cmd_q   <= '0;
      rdata_q <= '0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      rdata_q <= rdata_d;
      abort_q <= abort_d;
      err_q   <= err_d;
    end
  end

  // Write-back payload: load data only leaves the stage from DONE.
  always_comb begin
    wb_rdata = (state_q == ST_DONE) ? rdata_q : '0;
    wb_kill  = (state_q == ST_DONE) && abort_q;
  end

  mem_wb_reg u_mem_wb_reg (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .stall_i     (stall),
    .kill_wr_i   (wb_kill),
    .RegWrite_i  (RegWrite_i),
    .MemtoReg_i  (MemtoReg_i),
    .Rd_i        (Rd_i),
    .ALUResult_i (ALUResult_i),
    .ReadData_i  (wb_rdata),
    .RegWrite_o  (RegWrite_o),
    .MemtoReg_o  (MemtoReg_o),
    .Rd_o        (Rd_o),
    .ALUResult_o (ALUResult_o),
    .ReadData_o  (ReadData_o)
  );

  assign mem_req_o   = req;
  assign mem_we_o    = cmd_q.we;
  assign mem_addr_o  = cmd_q.addr;
  assign mem_wdata_o = cmd_q.wdata;
  assign stall_o     = stall;
  assign mem_err_o   = err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomised bench for mem_wb_stage with an instruction-level reference model.
module tb_mem_wb_stage;
  import cpu_pkg::*;

  localparam int T = ACK_TIMEOUT_DEFAULT;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        RegWrite_i = 1'b0, MemtoReg_i = 1'b0, MemRead_i = 1'b0, MemWrite_i = 1'b0;
  logic [4:0]  Rd_i = '0;
  logic [31:0] ALUResult_i = '0, DATAWr_i = '0;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        stall_o, RegWrite_o, MemtoReg_o;
  logic [4:0]  Rd_o;
  logic [31:0] ALUResult_o, ReadData_o;
  logic        mem_err_o;

  mem_wb_stage #(.ACK_TIMEOUT(T)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .Rd_i(Rd_i), .ALUResult_i(ALUResult_i), .DATAWr_i(DATAWr_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .Rd_o(Rd_o),
    .ALUResult_o(ALUResult_o), .ReadData_o(ReadData_o), .mem_err_o(mem_err_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  int txn_no = 0;

  // Expected MEM/WB contents and error flag.
  logic        exp_rw, exp_mtr, exp_err;
  logic [4:0]  exp_rd;
  logic [31:0] exp_alu, exp_rdata;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (txn %0d)", tag, got, exp, txn_no);
    end
  endtask

  task automatic check_wb();
    check_val("RegWrite_o",  32'(RegWrite_o), 32'(exp_rw));
    check_val("MemtoReg_o",  32'(MemtoReg_o), 32'(exp_mtr));
    check_val("Rd_o",        32'(Rd_o),       32'(exp_rd));
    check_val("ALUResult_o", ALUResult_o,     exp_alu);
    check_val("ReadData_o",  ReadData_o,      exp_rdata);
    check_val("mem_err_o",   32'(mem_err_o),  32'(exp_err));
  endtask

  task automatic model_reset();
    exp_rw = 0; exp_mtr = 0; exp_err = 0; exp_rd = '0; exp_alu = '0; exp_rdata = '0;
  endtask

  task automatic drive_instr(input logic rd_en, input logic wr_en, input logic rw, input logic mtr,
                             input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] wd);
    MemRead_i = rd_en; MemWrite_i = wr_en; RegWrite_i = rw; MemtoReg_i = mtr;
    Rd_i = rd; ALUResult_i = alu; DATAWr_i = wd;
  endtask

  // Non-memory instruction: one cycle, never stalls; stray acks ignored.
  task automatic run_nonmem(input logic rw, input logic mtr, input logic [4:0] rd,
                            input logic [31:0] alu, input logic ack_noise);
    txn_no++;
    drive_instr(1'b0, 1'b0, rw, mtr, rd, alu, $urandom);
    mem_ack_i = ack_noise; mem_rdata_i = $urandom;
    @(negedge clk_i);
    check_val("stall_nonmem", 32'(stall_o), 32'd0);
    check_val("req_nonmem",   32'(mem_req_o), 32'd0);
    check_wb();
    @(posedge clk_i);
    exp_rw = rw; exp_mtr = mtr; exp_rd = rd; exp_alu = alu; exp_rdata = '0;
    #1;
    mem_ack_i = 1'b0;
    $display("txn %0d alu rd=%0d res=%h", txn_no, rd, alu);
  endtask

  // Memory instruction: ack arrives in WAIT cycle delay+1 unless that exceeds T.
  task automatic run_mem(input logic rd_en, input logic wr_en, input logic rw, input logic mtr,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] wd,
                         input logic [31:0] rdv, input int delay, input logic ack_noise);
    logic aborted;
    int   nwait;
    aborted = (delay + 1 > T);
    nwait   = aborted ? T : delay + 1;
    txn_no++;
    drive_instr(rd_en, wr_en, rw, mtr, rd, alu, wd);
    mem_ack_i = ack_noise; mem_rdata_i = $urandom;
    // Issue cycle: stalled, no request yet.
    @(negedge clk_i);
    check_val("stall_issue", 32'(stall_o), 32'd1);
    check_val("req_issue",   32'(mem_req_o), 32'd0);
    check_wb();
    @(posedge clk_i);
    exp_rw = 0; exp_mtr = 0;
    #1;
    for (int k = 1; k <= nwait; k++) begin
      mem_ack_i   = (k == delay + 1);
      mem_rdata_i = (k == delay + 1) ? rdv : $urandom;
      @(negedge clk_i);
      check_val("req_wait",   32'(mem_req_o), 32'd1);
      check_val("stall_wait", 32'(stall_o), 32'd1);
      check_val("addr_wait",  mem_addr_o, alu);
      check_val("wdata_wait", mem_wdata_o, wd);
      check_val("we_wait",    32'(mem_we_o), 32'(wr_en));
      check_wb();
      @(posedge clk_i);
      exp_rw = 0; exp_mtr = 0;
      if (aborted && k == nwait) exp_err = 1'b1;
      #1;
    end
    // Completion cycle: no request, no stall, result written at its end.
    mem_ack_i = ack_noise; mem_rdata_i = $urandom;
    @(negedge clk_i);
    check_val("req_done",   32'(mem_req_o), 32'd0);
    check_val("stall_done", 32'(stall_o), 32'd0);
    check_wb();
    @(posedge clk_i);
    exp_rw    = aborted ? 1'b0 : rw;
    exp_mtr   = mtr;
    exp_rd    = rd;
    exp_alu   = alu;
    exp_rdata = (aborted || wr_en) ? 32'd0 : rdv;
    #1;
    mem_ack_i = 1'b0;
    $display("txn %0d %s addr=%h wait=%0d abort=%0d", txn_no, wr_en ? "store" : "load",
             alu, nwait, aborted);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int kind, delay;
    model_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_val("rst_req",   32'(mem_req_o), 32'd0);
    check_val("rst_we",    32'(mem_we_o), 32'd0);
    check_val("rst_addr",  mem_addr_o, 32'd0);
    check_val("rst_wdata", mem_wdata_o, 32'd0);
    check_wb();
    @(posedge clk_i); #1;
    rst_i = 1'b1;

    // Directed cases.
    run_nonmem(1'b1, 1'b0, 5'd5, 32'h0000_0010, 1'b0);
    run_mem(1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
    run_mem(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h200, 32'h1234_5678, 32'h0, 3, 1'b0);
    run_mem(1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 32'h4, 32'h0, 32'h1111_2222, 0, 1'b0);
    run_mem(1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h8, 32'h0, 32'h3333_4444, 0, 1'b0);
    run_mem(1'b1, 1'b1, 1'b1, 1'b0, 5'd2, 32'h40, 32'hCAFE_F00D, 32'h5555_6666, 1, 1'b1);
    run_mem(1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 32'h80, 32'h0, 32'hA5A5_5A5A, T - 1, 1'b0);
    run_nonmem(1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1);

    // Random mix, occasionally straddling the timeout boundary.
    for (int n = 0; n < 40; n++) begin
      kind  = $urandom_range(0, 3);
      delay = ($urandom_range(0, 7) == 0) ? $urandom_range(T - 2, T + 2) : $urandom_range(0, 5);
      if (kind == 0)
        run_nonmem(1'($urandom), 1'($urandom), 5'($urandom), $urandom, 1'($urandom_range(0, 2) == 0));
      else
        run_mem(kind != 2, kind != 1, 1'($urandom), 1'($urandom), 5'($urandom), $urandom,
                $urandom, $urandom, delay, 1'($urandom_range(0, 2) == 0));
    end

    // Timeout: load never acknowledged.
    run_mem(1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 32'h180, 32'h0, 32'h0, T + 5, 1'b0);
    run_nonmem(1'b1, 1'b0, 5'd7, 32'h77, 1'b0);

    // Reset in the third WAIT cycle of a load.
    txn_no++;
    drive_instr(1'b1, 1'b0, 1'b1, 1'b1, 5'd10, 32'h300, 32'h0);
    mem_ack_i = 1'b0;
    repeat (3) begin
      @(posedge clk_i); #1;
    end
    check_val("req_before_rst", 32'(mem_req_o), 32'd1);
    rst_i = 1'b0;
    #1;
    model_reset();
    check_val("req_in_rst",   32'(mem_req_o), 32'd0);
    check_val("we_in_rst",    32'(mem_we_o), 32'd0);
    check_val("addr_in_rst",  mem_addr_o, 32'd0);
    check_val("wdata_in_rst", mem_wdata_o, 32'd0);
    check_wb();
    $display("txn %0d reset during WAIT", txn_no);
    @(posedge clk_i); #1;
    drive_instr(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    rst_i = 1'b1;
    // Late ack after reset, then normal loads.
    run_nonmem(1'b1, 1'b0, 5'd11, 32'h1234, 1'b1);
    run_mem(1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 32'h304, 32'h0, 32'hBEEF_0001, 0, 1'b1);
    run_mem(1'b1, 1'b0, 1'b1, 1'b1, 5'd13, 32'h308, 32'h0, 32'hBEEF_0002, 2, 1'b0);
    @(negedge clk_i);
    check_wb();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 16, max wait cycles for mem_ack_i before abort (legal range 1..255).
REQ-002 SHALL have clk_i  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have rst_i  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i  in  1 each  control bits from EX/MEM register.
REQ-005 SHALL have Rd_i  in  5  destination register; ALUResult_i  in  32  address/result; DATAWr_i  in  32  store data.
REQ-006 SHALL have mem_req_o  out  1; mem_we_o  out  1; mem_addr_o  out  32; mem_wdata_o  out  32  data-memory request port.
REQ-007 SHALL have mem_ack_i  in  1  access complete; mem_rdata_i  in  32  load data, valid with mem_ack_i.
REQ-008 SHALL have stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle.
REQ-009 SHALL have RegWrite_o, MemtoReg_o  out  1 each; Rd_o  out  5; ALUResult_o, ReadData_o  out  32  MEM/WB register.
REQ-010 SHALL have mem_err_o  out  1  sticky access-timeout flag.

Function
REQ-011 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-012 IDLE, MemRead_i|MemWrite_i=1: SHALL capture addr=ALUResult_i, wdata=DATAWr_i, we=MemWrite_i, clear timeout counter, go WAIT.
REQ-013 IDLE, no memory op: SHALL stay IDLE; instruction passes with 1-cycle latency.
REQ-014 WAIT: mem_req_o=1 with mem_addr_o/mem_wdata_o/mem_we_o held constant from captured values; otherwise mem_req_o=0.
REQ-015 WAIT, mem_ack_i=1: SHALL latch mem_rdata_i (loads only), go DONE.
REQ-016 WAIT, no ack: counter increments; when counter reaches ACK_TIMEOUT-1 without ack, SHALL abort, set mem_err_o, go DONE.
REQ-017 DONE: SHALL go IDLE next cycle unconditionally; mem_req_o=0.
REQ-018 stall_o SHALL be combinational: 1 in WAIT, 1 in IDLE with memory op present, 0 otherwise (including DONE).
REQ-019 MemRead_i and MemWrite_i both 1: SHALL be treated as a write (mem_we_o=1).
REQ-020 MEM/WB register SHALL load RegWrite_i, MemtoReg_i, Rd_i, ALUResult_i on every edge where stall_o=0; ReadData_o loads latched load data (0 for non-loads).
REQ-021 Edge where stall_o=1: SHALL load a bubble (RegWrite_o=0, MemtoReg_o=0, others unchanged).
REQ-022 Aborted access: DONE cycle SHALL load RegWrite_o=0, ReadData_o=0.
REQ-023 mem_ack_i outside WAIT SHALL be ignored.
REQ-024 Minimum memory-op occupancy: 3 cycles (IDLE, WAIT, DONE), 2 of them stalled; result visible at edge ending DONE.
REQ-025 mem_err_o SHALL remain 1 until reset.

Reset
REQ-026 rst_i=0 SHALL immediately force: state IDLE, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, counter 0, mem_err_o=0, all MEM/WB outputs 0.
REQ-027 Reset mid-WAIT SHALL drop mem_req_o in the same cycle; a subsequent mem_ack_i SHALL be ignored.
REQ-028 After rst_i deasserts, first active edge SHALL behave as IDLE.

Structure
REQ-029 FSM state enum and ACK_TIMEOUT default SHALL live in shared package cpu_pkg.
REQ-030 MEM/WB register with bubble insertion SHALL be sub-module mem_wb_reg; FSM, counter, memory port stay in mem_wb_stage.

Verification
REQ-031 Non-mem op: RegWrite_i=1, Rd_i=5, ALUResult_i=0x0000_0010 -> next edge Rd_o=5, ALUResult_o=0x10, RegWrite_o=1, stall_o never 1.
REQ-032 Load, ack in first WAIT cycle: addr 0x100, mem_rdata_i=0xDEAD_BEEF -> stall_o high 2 cycles, mem_req_o 1 cycle, ReadData_o=0xDEADBEEF, MemtoReg_o=1 at DONE edge.
REQ-033 Store, ack after 4 WAIT cycles: addr 0x200, data 0x1234_5678 -> mem_req_o high 4 cycles, mem_we_o=1, address/data stable throughout, stall_o high 5 cycles, bubbles on WB.
REQ-034 Load, no ack, ACK_TIMEOUT=16 -> mem_req_o high exactly 16 cycles, mem_err_o=1 thereafter, RegWrite_o=0, ReadData_o=0.
REQ-035 rst_i low during 3rd WAIT cycle -> mem_req_o=0 same cycle, all outputs 0; late mem_ack_i has no effect; next load completes normally.
REQ-036 Back-to-back loads to 0x4, 0x8 with immediate ack -> two distinct 3-cycle sequences, no reissue of first address.
